bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It converts a 32-bit value from the pipeline's output/IO register into packed BCD digits. Each 4-bit digit feeds one `decoder_hex` instance (digit 0 drives HEX0). A start/busy/done handshake lets the IO logic refresh the HEX bank whenever the displayed value changes.

## Interface
- `DATA_W`, 32: input width; latency scales with it; fixed at 32 for the HEX bank.
- `OUT_DIGITS`, 8: BCD digits presented on the output, one per HEX display; must be ≤ 10.
- `i_clk`  in  1  single clock, rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  request conversion of `i_bin_data`; sampled only in IDLE.
- `i_signed`  in  1  1 = treat `i_bin_data` as two's complement; sampled with `i_start`.
- `i_bin_data`  in  DATA_W  value to convert; sampled with `i_start`.
- `o_busy`  out  1  high while state ≠ IDLE.
- `o_done`  out  1  one-cycle pulse when the output registers update.
- `o_bcd_data`  out  4·OUT_DIGITS  packed BCD; digit k at [4k+3:4k].
- `o_neg`  out  1  result was negative (signed mode only).
- `o_overflow`  out  1  magnitude > 10^OUT_DIGITS − 1.

## Operation
- FSM states: IDLE → SHIFT → DONE → IDLE.
- **IDLE:** on `i_start` = 1, capture the magnitude and latch the sign, clear the 40-bit BCD accumulator (10 digits), set bit counter = 0, and go to SHIFT.
  - Magnitude = −`i_bin_data` if `i_signed` and bit 31 is set; otherwise `i_bin_data`.
  - Sign latch = `i_signed` & bit 31.
  - `i_start` = 0: remain in IDLE.
- **SHIFT:** each cycle, every accumulator digit ≥ 5 gets +3. The {accumulator, magnitude} register then shifts left 1. Counter increments; after the shift with counter = DATA_W−1, go to DONE.
- **DONE:** commit the outputs, pulse `o_done`, return to IDLE.
  - `o_overflow` = any accumulator digit above index OUT_DIGITS−1 is nonzero.
  - Overflow: `o_bcd_data` = all digits 9. Otherwise: low OUT_DIGITS digits of the accumulator.
  - `o_neg` = sign latch.
- Magnitude arithmetic is DATA_W bits, unsigned. Signed 32'h8000_0000 → magnitude 2147483648 (overflows at 8 digits).
- `i_start` while busy is ignored; no queueing.
- Outputs hold their last committed value until the next DONE; the HEX display never shows intermediate state.
- Reset (asynchronous, any state): state = IDLE, `o_busy` = 0, `o_done` = 0, `o_bcd_data` = 0, `o_neg` = 0, `o_overflow` = 0, internal registers cleared. A conversion in flight is discarded with no `o_done`.

## Timing
- Start accepted at edge E0. SHIFT occupies edges E1..E32. DONE commit at edge E33.
- Latency: DATA_W+1 = 33 cycles from the accepting edge to the outputs and `o_done` being visible.
- `o_busy` is high after E0 until E33; it is low in the same cycle `o_done` is high.
- A new `i_start` during the `o_done` cycle is accepted at the next edge: back-to-back throughput is one conversion per 34 cycles.
- `o_done` is high exactly one cycle per accepted start.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `bin2bcd_pkg` holds:
  - `state_e` enum {IDLE, SHIFT, DONE}.
  - `ACC_DIGITS` = 10.
  - `BCD_DIGIT_W` = 4.
  - `BCD_ALL_NINES` constant.
- One sub-module, `bcd_digit_adj`: combinational 4-bit "≥5 → +3", instantiated ACC_DIGITS times via generate.
- Top: FSM, counter, shift register, output commit.

## Test plan
- `i_signed` = 0, `i_bin_data` = 12345678, pulse `i_start` → `o_done` at 33 cycles, `o_bcd_data` = 32'h1234_5678, `o_neg` = 0, `o_overflow` = 0.
- `i_signed` = 1, `i_bin_data` = 32'hFFFF_FFD6 (−42) → `o_bcd_data` = 32'h0000_0042, `o_neg` = 1. Same data with `i_signed` = 0 → `o_overflow` = 1, `o_bcd_data` = 32'h9999_9999, `o_neg` = 0.
- Boundaries:
  - 99999999 → 32'h9999_9999, `o_overflow` = 0.
  - 100000000 → `o_overflow` = 1, all 9s.
  - 0 → 32'h0000_0000.
- Start 5 at E0, pulse `i_start` with 7 at E10 → only one `o_done`, at E33, result 5. Start 7 during the `o_done` cycle → accepted; result 7 after 33 more cycles.
- Assert `i_reset` low asynchronously mid-SHIFT (cycle 10) → all outputs 0 immediately, `o_busy` = 0, no `o_done` afterwards. Release, start 9 → correct result at 33 cycles.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam int unsigned ACC_DIGITS  = 10;
  localparam int unsigned BCD_DIGIT_W = 4;

  localparam logic [ACC_DIGITS*BCD_DIGIT_W-1:0] BCD_ALL_NINES = {ACC_DIGITS{4'h9}};

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= BCD_DIGIT_W'(5)) adjusted = digit + BCD_DIGIT_W'(3);
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Shift-and-add-3 binary-to-BCD converter, one input bit per clock, with a
// start/busy/done handshake and registered, hold-until-commit outputs.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned OUT_DIGITS = 8
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_start,
  input  logic                              i_signed,
  input  logic [DATA_W-1:0]                 i_bin_data,
  output logic                              o_busy,
  output logic                              o_done,
  output logic [OUT_DIGITS*BCD_DIGIT_W-1:0] o_bcd_data,
  output logic                              o_neg,
  output logic                              o_overflow
);

  localparam int unsigned ACC_W = ACC_DIGITS * BCD_DIGIT_W;
  localparam int unsigned OUT_W = OUT_DIGITS * BCD_DIGIT_W;
  localparam int unsigned CNT_W = $clog2(DATA_W);

  state_e                    state;
  logic [CNT_W-1:0]          cnt;
  logic [ACC_W-1:0]          acc;
  logic [ACC_W-1:0]          adj;
  logic [DATA_W-1:0]         mag;
  logic                      sign;
  logic [ACC_W+DATA_W-1:0]   shifted;
  logic                      ovf;

  for (genvar g = 0; g < ACC_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Corrected digits and the remaining magnitude shift as one register.
  assign shifted = {adj, mag} << 1;

  always_comb begin
    ovf = 1'b0;
    for (int unsigned k = OUT_DIGITS; k < ACC_DIGITS; k++) begin
      if (acc[k*BCD_DIGIT_W +: BCD_DIGIT_W] != '0) ovf = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      mag        <= '0;
      sign       <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_bcd_data <= '0;
      o_neg      <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            sign   <= i_signed & i_bin_data[DATA_W-1];
            mag    <= (i_signed && i_bin_data[DATA_W-1]) ? -i_bin_data : i_bin_data;
            acc    <= '0;
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          {acc, mag} <= shifted;
          cnt        <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) state <= DONE;
        end
        DONE: begin
          o_bcd_data <= ovf ? BCD_ALL_NINES[OUT_W-1:0] : acc[OUT_W-1:0];
          o_overflow <= ovf;
          o_neg      <= sign;
          o_done     <= 1'b1;
          o_busy     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed table, handshake corner cases,
// asynchronous reset mid-conversion, and randomized values against a decimal model.
module tb_bin2bcd_seq;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_signed = 1'b0;
  logic [31:0] i_bin_data = '0;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_bcd_data;
  logic        o_neg;
  logic        o_overflow;

  int vectors = 0;
  int miscompares = 0;

  bin2bcd_seq #(.DATA_W(32), .OUT_DIGITS(8)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_signed   (i_signed),
    .i_bin_data (i_bin_data),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_bcd_data (o_bcd_data),
    .o_neg      (o_neg),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          sgn;
    logic [31:0] data;
    logic [31:0] bcd;
    bit          neg;
    bit          ovf;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Decimal reference: magnitude by plain arithmetic, digits by repeated division.
  function automatic void model(input bit sgn, input logic [31:0] d,
                                output logic [31:0] bcd, output bit neg, output bit ovf);
    longint unsigned m;
    neg = sgn && d[31];
    m   = neg ? (64'h1_0000_0000 - longint'(d)) : longint'(d);
    ovf = (m > 64'd99999999);
    bcd = '0;
    if (ovf) bcd = 32'h9999_9999;
    else begin
      for (int k = 0; k < 8; k++) begin
        bcd[4*k +: 4] = 4'(m % 10);
        m = m / 10;
      end
    end
  endfunction

  // Starts a conversion at the next edge and checks latency, handshake and result.
  task automatic run(input string name, input bit sgn, input logic [31:0] d,
                     input logic [31:0] eb, input bit en, input bit eo);
    int lat;
    lat = 0;
    i_start    = 1'b1;
    i_signed   = sgn;
    i_bin_data = d;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check({name, ".busy_after_start"}, 64'(o_busy), 64'd1);
    for (int n = 1; n <= 40; n++) begin
      @(posedge i_clk); #1;
      if (o_done) begin
        lat = n;
        break;
      end
    end
    check({name, ".latency"}, 64'(lat), 64'd33);
    check({name, ".busy_at_done"}, 64'(o_busy), 64'd0);
    check({name, ".bcd"}, 64'(o_bcd_data), 64'(eb));
    check({name, ".neg"}, 64'(o_neg), 64'(en));
    check({name, ".ovf"}, 64'(o_overflow), 64'(eo));
  endtask

  initial begin
    logic [31:0] eb;
    bit          en;
    bit          eo;
    logic [31:0] d;
    bit          s;
    int          dones;
    int          first_done;

    tbl[0]  = '{1'b0, 32'd12345678,   32'h1234_5678, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'hFFFF_FFD6,  32'h0000_0042, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 32'hFFFF_FFD6,  32'h9999_9999, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 32'd99999999,   32'h9999_9999, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'd100000000,  32'h9999_9999, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 32'd0,          32'h0000_0000, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 32'h8000_0000,  32'h9999_9999, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 32'h7FFF_FFFF,  32'h9999_9999, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 32'hFFFF_FFFF,  32'h0000_0001, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 32'hFA0A_1F01,  32'h9999_9999, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 32'd90817263,   32'h9081_7263, 1'b0, 1'b0};

    #12;
    check("reset.busy", 64'(o_busy), 64'd0);
    check("reset.done", 64'(o_done), 64'd0);
    check("reset.bcd",  64'(o_bcd_data), 64'd0);
    check("reset.neg",  64'(o_neg), 64'd0);
    check("reset.ovf",  64'(o_overflow), 64'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    @(posedge i_clk); #1;

    foreach (tbl[i])
      run($sformatf("tbl%0d", i), tbl[i].sgn, tbl[i].data, tbl[i].bcd, tbl[i].neg, tbl[i].ovf);

    // Done is a single-cycle pulse.
    @(posedge i_clk); #1;
    check("done_pulse_width", 64'(o_done), 64'd0);

    // A second start while busy must be ignored.
    dones = 0;
    first_done = 0;
    i_start = 1'b1; i_signed = 1'b0; i_bin_data = 32'd5;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 10) begin i_start = 1'b1; i_bin_data = 32'd7; end
      if (n == 11) i_start = 1'b0;
      @(posedge i_clk); #1;
      if (o_done) begin
        dones++;
        first_done = n;
        break;
      end
    end
    check("ignored_start.dones", 64'(dones), 64'd1);
    check("ignored_start.latency", 64'(first_done), 64'd33);
    check("ignored_start.bcd", 64'(o_bcd_data), 64'h5);

    // Start issued in the done cycle is accepted at the next edge.
    run("back_to_back", 1'b0, 32'd7, 32'h7, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a conversion.
    i_start = 1'b1; i_bin_data = 32'd123;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (10) @(posedge i_clk);
    #2;
    i_reset = 1'b0;
    #1;
    check("async_rst.busy", 64'(o_busy), 64'd0);
    check("async_rst.done", 64'(o_done), 64'd0);
    check("async_rst.bcd",  64'(o_bcd_data), 64'd0);
    check("async_rst.neg",  64'(o_neg), 64'd0);
    check("async_rst.ovf",  64'(o_overflow), 64'd0);
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge i_clk); #1;
      if (o_done || o_busy) dones++;
    end
    check("async_rst.no_done", 64'(dones), 64'd0);
    run("after_reset", 1'b0, 32'd9, 32'h9, 1'b0, 1'b0);

    // Randomized values against the decimal model.
    for (int r = 0; r < 40; r++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       d = $urandom;
        1:       d = 32'($urandom_range(0, 99999999));
        default: d = -32'($urandom_range(0, 99999999));
      endcase
      model(s, d, eb, en, eo);
      run($sformatf("rand%0d", r), s, d, eb, en, eo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
